// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority arbiter putting fetch and load/store requests onto one Wishbone-classic master port
// Ports: clk/rst (sync, active-high); if_req/if_addr -> if_rdata/if_ack (fetch);
// mem_req/mem_we/mem_sel/mem_addr/mem_wdata -> mem_rdata/mem_ack (load/store); flush cancels a pending fetch;
// bus_cyc/bus_stb/bus_we/bus_sel/bus_addr/bus_wdata out, bus_rdata/bus_ack in; bus_err flags a timed-out access;
// stallreq_if/stallreq_mem are combinational stall requests to the pipeline.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  input  logic        flush,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        stallreq_if,
  output logic        stallreq_mem
);
  typedef enum logic [1:0] {IDLE, IF_BUS, MEM_BUS, DONE} state_t;
  localparam logic [7:0] last = 8'(TIMEOUT - 1);
  state_t state;
  logic [7:0] cnt;
  logic cancel;
  assign stallreq_mem = mem_req & ~mem_ack;
  assign stallreq_if = if_req & ~if_ack & ~flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cancel <= 1'b0;
      bus_cyc <= 1'b0;
      bus_stb <= 1'b0;
      bus_we <= 1'b0;
      bus_sel <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      if_rdata <= '0;
      mem_rdata <= '0;
      if_ack <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            state <= MEM_BUS;
            cnt <= '0;
            bus_cyc <= 1'b1;
            bus_stb <= 1'b1;
            bus_we <= mem_we;
            bus_sel <= mem_sel;
            bus_addr <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (if_req && !flush) begin
            state <= IF_BUS;
            cnt <= '0;
            cancel <= 1'b0;
            bus_cyc <= 1'b1;
            bus_stb <= 1'b1;
            bus_we <= 1'b0;
            bus_sel <= 4'b1111;
            bus_addr <= if_addr;
          end
        end
        IF_BUS, MEM_BUS: begin
          // a flush seen on any cycle of the fetch suppresses its delivery
          cancel <= cancel | ((state == IF_BUS) & flush);
          // an ack arriving on the final wait cycle wins over the timeout
          if (bus_ack || cnt == last) begin
            state <= DONE;
            bus_cyc <= 1'b0;
            bus_stb <= 1'b0;
            if (state == MEM_BUS) begin
              mem_ack <= 1'b1;
              mem_rdata <= bus_ack ? bus_rdata : '0;
              bus_err <= ~bus_ack;
            end else if (!(cancel | flush)) begin
              if_ack <= 1'b1;
              if_rdata <= bus_ack ? bus_rdata : '0;
              bus_err <= ~bus_ack;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          // one dead cycle lets the requester drop the request it just got acked
          state <= IDLE;
          if_ack <= 1'b0;
          mem_ack <= 1'b0;
          bus_err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a transaction-level model checked every cycle
module tb_mem_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst;
  logic if_req, mem_req, mem_we, flush;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0] mem_sel;
  logic bus_ack = 1'b0;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic if_ack, mem_ack, bus_cyc, bus_stb, bus_we, bus_err, stallreq_if, stallreq_mem;
  logic [3:0] bus_sel;
  int n_chk = 0, n_fail = 0;
  int n_stb = 0, stb_age = 0, stb_len = 0, ack_delay = 1;
  int n_ia = 0, n_ma = 0, n_err = 0;
  logic force_ack = 1'b0;
  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .flush(flush),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // slave: acks on the ack_delay-th cycle of a strobe (0 = never), or always when force_ack
  always @(posedge clk) begin
    #2;
    if (bus_stb) begin
      stb_age = stb_age + 1;
      if (stb_age == 1) n_stb = n_stb + 1;
    end else begin
      if (stb_age > 0) stb_len = stb_age;
      stb_age = 0;
    end
    bus_ack = force_ack || (bus_stb && ack_delay > 0 && stb_age == ack_delay);
  end
  // model: one outstanding transaction with an owner, a deadline and a cancelled mark
  typedef enum {NONE, FETCH, MEM, RET} owner_t;
  owner_t owner = NONE;
  int cy = 0, deadline = 0;
  logic mv = 1'b0, dropped = 1'b0;
  logic e_cyc, e_we, e_ia, e_ma, e_err;
  logic [3:0] e_sel;
  logic [31:0] e_addr, e_wdata, e_ir, e_mr;
  always @(posedge clk) begin
    cy <= cy + 1;
    if (rst) begin
      mv <= 1'b1;
      owner <= NONE;
      e_cyc <= 1'b0; e_we <= 1'b0; e_sel <= '0; e_addr <= '0; e_wdata <= '0;
      e_ir <= '0; e_mr <= '0; e_ia <= 1'b0; e_ma <= 1'b0; e_err <= 1'b0;
    end else if (owner == RET) begin
      owner <= NONE;
      e_ia <= 1'b0; e_ma <= 1'b0; e_err <= 1'b0;
    end else if (owner == NONE) begin
      if (mem_req) begin
        owner <= MEM;
        e_cyc <= 1'b1; e_we <= mem_we; e_sel <= mem_sel; e_addr <= mem_addr; e_wdata <= mem_wdata;
        deadline <= cy + TO;
      end else if (if_req && !flush) begin
        owner <= FETCH;
        e_cyc <= 1'b1; e_we <= 1'b0; e_sel <= 4'hF; e_addr <= if_addr;
        deadline <= cy + TO;
        dropped <= 1'b0;
      end
    end else begin
      if (bus_ack || cy == deadline) begin
        owner <= RET;
        e_cyc <= 1'b0;
        if (owner == MEM) begin
          e_ma <= 1'b1; e_err <= !bus_ack; e_mr <= bus_ack ? bus_rdata : 32'h0;
        end else if (!(dropped || flush)) begin
          e_ia <= 1'b1; e_err <= !bus_ack; e_ir <= bus_ack ? bus_rdata : 32'h0;
        end
      end
      if (owner == FETCH && flush) dropped <= 1'b1;
    end
  end
  always @(negedge clk) begin
    if (mv) begin
      chk("bus_cyc", {31'b0, bus_cyc}, {31'b0, e_cyc});
      chk("bus_stb", {31'b0, bus_stb}, {31'b0, e_cyc});
      chk("bus_we", {31'b0, bus_we}, {31'b0, e_we});
      chk("bus_sel", {28'b0, bus_sel}, {28'b0, e_sel});
      chk("bus_addr", bus_addr, e_addr);
      chk("bus_wdata", bus_wdata, e_wdata);
      chk("if_rdata", if_rdata, e_ir);
      chk("mem_rdata", mem_rdata, e_mr);
      chk("if_ack", {31'b0, if_ack}, {31'b0, e_ia});
      chk("mem_ack", {31'b0, mem_ack}, {31'b0, e_ma});
      chk("bus_err", {31'b0, bus_err}, {31'b0, e_err});
      chk("stallreq_if", {31'b0, stallreq_if}, {31'b0, if_req & ~e_ia & ~flush});
      chk("stallreq_mem", {31'b0, stallreq_mem}, {31'b0, mem_req & ~e_ma});
    end
    if (if_ack) n_ia++;
    if (mem_ack) n_ma++;
    if (bus_err) n_err++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_for(input bit is_mem, output int lat);
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!(is_mem ? mem_ack : if_ack) && lat < 30);
    if (!(is_mem ? mem_ack : if_ack)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_ack: no %s ack within 30 cycles", is_mem ? "mem" : "if");
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, s0, ia0, ma0, er0;
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; flush = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_sel = '0; bus_rdata = '0;
    tick(2);
    chk("rst_cyc", {31'b0, bus_cyc}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    rst = 1'b0;
    tick(1);
    // single fetch, minimum latency, req held through ack
    bus_rdata = 32'hDEADBEEF; s0 = n_stb; if_addr = 32'h100; if_req = 1'b1;
    wait_for(1'b0, lat);
    chk("t1_lat", lat, 2);
    chk("t1_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_addr", bus_addr, 32'h100);
    chk("t1_we", {31'b0, bus_we}, 32'h0);
    chk("t1_err", {31'b0, bus_err}, 32'h0);
    tick(1); if_req = 1'b0; tick(3);
    chk("t1_one_txn", n_stb - s0, 1);
    // store beats fetch, fetch follows after DONE
    bus_rdata = 32'h55AA55AA; s0 = n_stb; ia0 = n_ia;
    if_addr = 32'h300; if_req = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_sel = 4'b0011; mem_wdata = 32'h1234;
    wait_for(1'b1, lat);
    chk("t2_mem_lat", lat, 2);
    chk("t2_we", {31'b0, bus_we}, 32'h1);
    chk("t2_sel", {28'b0, bus_sel}, 32'h3);
    chk("t2_addr", bus_addr, 32'h200);
    chk("t2_wdata", bus_wdata, 32'h1234);
    chk("t2_mem_rdata", mem_rdata, 32'h55AA55AA);
    chk("t2_no_if_ack", n_ia - ia0, 0);
    mem_req = 1'b0; mem_we = 1'b0; bus_rdata = 32'hCAFEF00D;
    wait_for(1'b0, lat);
    chk("t2_if_lat", lat, 3);
    chk("t2_if_rdata", if_rdata, 32'hCAFEF00D);
    chk("t2_if_addr", bus_addr, 32'h300);
    chk("t2_if_sel", {28'b0, bus_sel}, 32'hF);
    chk("t2_two_txn", n_stb - s0, 2);
    if_req = 1'b0; tick(2);
    // silent slave: timeout after TO wait cycles
    ack_delay = 0; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400; mem_sel = 4'hF;
    wait_for(1'b1, lat);
    chk("t3_lat", lat, TO + 1);
    chk("t3_err", {31'b0, bus_err}, 32'h1);
    chk("t3_rdata", mem_rdata, 32'h0);
    mem_req = 1'b0; tick(2);
    chk("t3_stb_len", stb_len, TO);
    // ack on the timeout cycle is a success
    ack_delay = TO; bus_rdata = 32'h0BADF00D; if_addr = 32'h500; if_req = 1'b1;
    wait_for(1'b0, lat);
    chk("t4_lat", lat, TO + 1);
    chk("t4_err", {31'b0, bus_err}, 32'h0);
    chk("t4_rdata", if_rdata, 32'h0BADF00D);
    tick(1); if_req = 1'b0; tick(2);
    // flush during fetch: bus completes, no delivery
    ack_delay = 3; bus_rdata = 32'h11111111; ia0 = n_ia; er0 = n_err; s0 = n_stb;
    if_addr = 32'h600; if_req = 1'b1;
    tick(1); flush = 1'b1; #1;
    chk("t5_stall_if", {31'b0, stallreq_if}, 32'h0);
    tick(1); flush = 1'b0; if_req = 1'b0;
    tick(8);
    chk("t5_no_ack", n_ia - ia0, 0);
    chk("t5_no_err", n_err - er0, 0);
    chk("t5_one_txn", n_stb - s0, 1);
    chk("t5_rdata", if_rdata, 32'h0BADF00D);
    // reset during a store
    ack_delay = 0; ma0 = n_ma;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h700; mem_sel = 4'h5; mem_wdata = 32'h99;
    tick(3); rst = 1'b1; #1;
    chk("t6_stall_mem_rst", {31'b0, stallreq_mem}, 32'h1);
    tick(1);
    chk("t6_cyc", {31'b0, bus_cyc}, 32'h0);
    chk("t6_stb", {31'b0, bus_stb}, 32'h0);
    chk("t6_we", {31'b0, bus_we}, 32'h0);
    chk("t6_sel", {28'b0, bus_sel}, 32'h0);
    chk("t6_addr", bus_addr, 32'h0);
    chk("t6_wdata", bus_wdata, 32'h0);
    chk("t6_if_rdata", if_rdata, 32'h0);
    mem_req = 1'b0; rst = 1'b0; tick(4);
    chk("t6_no_ack", n_ma - ma0, 0);
    // stray ack in IDLE, then flush blocking a fetch in IDLE
    force_ack = 1'b1; s0 = n_stb; ia0 = n_ia; ma0 = n_ma;
    tick(3); force_ack = 1'b0; tick(1);
    chk("t7_no_stb", n_stb - s0, 0);
    chk("t7_no_ack", (n_ia - ia0) + (n_ma - ma0), 0);
    if_addr = 32'h800; if_req = 1'b1; flush = 1'b1;
    tick(3);
    chk("t7_flush_blocks", n_stb - s0, 0);
    flush = 1'b0; ack_delay = 2; bus_rdata = 32'h87654321;
    wait_for(1'b0, lat);
    chk("t7_lat", lat, 3);
    chk("t7_rdata", if_rdata, 32'h87654321);
    if_req = 1'b0; tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, bus cycles to wait for bus_ack before forced termination; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  instruction-fetch read request; held stable with if_addr until if_ack.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_rdata / if_ack  out  32 / 1  fetch data; one-cycle completion pulse.
REQ-007 mem_req / mem_we  in  1 / 1  load/store request; write enable; held stable with the other mem_* inputs until mem_ack.
REQ-008 mem_sel / mem_addr / mem_wdata  in  4 / 32 / 32  byte lanes, address, store data.
REQ-009 mem_rdata / mem_ack  out  32 / 1  load data; one-cycle completion pulse.
REQ-010 flush  in  1  pipeline flush; cancels delivery of a pending fetch.
REQ-011 bus_cyc, bus_stb, bus_we  out  1 each  Wishbone-classic master controls.
REQ-012 bus_sel / bus_addr / bus_wdata  out  4 / 32 / 32  registered master outputs.
REQ-013 bus_rdata / bus_ack  in  32 / 1  slave data and acknowledge.
REQ-014 bus_err  out  1  pulses with if_ack or mem_ack when the transaction timed out.
REQ-015 stallreq_if / stallreq_mem  out  1 / 1  stall requests to the pipeline controller.

Function
REQ-016 FSM states IDLE, IF_BUS, MEM_BUS, DONE; all bus_* and *_rdata outputs registered.
REQ-017 IDLE: mem_req=1 -> MEM_BUS; else if_req=1 and flush=0 -> IF_BUS; else stay; mem_req has fixed priority over if_req.
REQ-018 On entering IF_BUS: bus_cyc=bus_stb=1, bus_we=0, bus_sel=4'b1111, bus_addr=if_addr.
REQ-019 On entering MEM_BUS: bus_cyc=bus_stb=1, bus_we=mem_we, bus_sel=mem_sel, bus_addr=mem_addr, bus_wdata=mem_wdata.
REQ-020 Bus outputs are held constant while in IF_BUS/MEM_BUS until bus_ack=1 or timeout.
REQ-021 bus_ack=1 in IF_BUS/MEM_BUS: next cycle bus_cyc=bus_stb=0, bus_rdata captured to requester's rdata, state DONE.
REQ-022 DONE lasts exactly one cycle: requester's *_ack=1; then IDLE; it blocks re-issue of a request the pipeline has not yet retired.
REQ-023 Minimum latency: req sampled in IDLE at cycle N, bus_stb high N+1, bus_ack in N+1, *_ack in N+2.
REQ-024 Timeout counter: cleared on entering IF_BUS/MEM_BUS, increments each cycle without bus_ack; on reaching TIMEOUT -> drop cyc/stb, DONE with *_ack=1, bus_err=1, rdata=32'h0.
REQ-025 bus_ack in the same cycle the counter reaches TIMEOUT counts as success (bus_err=0).
REQ-026 flush=1 at any cycle of IF_BUS: fetch remains pending-cancelled; bus transaction still completes; DONE issues no if_ack and no bus_err; if_rdata unchanged.
REQ-027 flush has no effect on MEM_BUS transactions.
REQ-028 stallreq_mem = mem_req & ~mem_ack (combinational).
REQ-029 stallreq_if = if_req & ~if_ack & ~flush (combinational).
REQ-030 bus_ack outside IF_BUS/MEM_BUS is ignored.
REQ-031 if_ack, mem_ack, bus_err are never asserted simultaneously with one another except bus_err with its owner's ack.

Reset
REQ-032 rst=1 at a rising edge: state IDLE, bus_cyc=bus_stb=bus_we=0, bus_sel=0, bus_addr=bus_wdata=0, if_rdata=mem_rdata=0, if_ack=mem_ack=bus_err=0, counter=0.
REQ-033 Reset mid-transaction aborts it immediately: cyc/stb low the cycle after the reset edge, no ack or error delivered.
REQ-034 stallreq_* follow REQ-028/029 regardless of rst.

Verification
REQ-035 if_req=1, if_addr=0x100, slave acks with data 0xDEADBEEF one cycle after stb -> bus_addr=0x100, bus_we=0, if_ack pulse with if_rdata=0xDEADBEEF at N+2, single bus cycle.
REQ-036 if_req and mem_req (we=1, addr=0x200, sel=4'b0011, wdata=0x1234) both high in IDLE -> store issued first, mem_ack; fetch issued after DONE->IDLE.
REQ-037 Slave never acks, TIMEOUT=4 -> cyc/stb drop after 4 wait cycles, mem_ack=1 with bus_err=1, mem_rdata=0.
REQ-038 flush pulsed during IF_BUS, ack after 3 cycles -> bus cycle completes, no if_ack, if_rdata unchanged, stallreq_if low while flush high.
REQ-039 rst asserted during MEM_BUS with ack pending -> all outputs at REQ-032 values next cycle, no mem_ack.
REQ-040 Requester holds req through its ack pulse -> exactly one bus transaction per request (DONE prevents duplicate).
